// File: rtl/decoder_mc.sv
// Multi-cycle picoMIPS instruction decoder: combinational decode in RUN, with stall
// states for wave-memory and switch operands, branch-status channels and a timed LED latch.
module decoder_mc #(
  parameter int  OPW      = 6,
  parameter int  NCH      = 2,
  parameter int  WAVE_TO  = 15,
  parameter int  LED_HOLD = 8,
  parameter bit  SW_WAIT  = 1'b1,
  localparam int SELW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [OPW-1:0]  opcode,
  input  logic [3:0]      flags,
  input  logic [SELW-1:0] br_sel,
  input  logic            branch_condition,
  input  logic [NCH-1:0]  branch_status,
  input  logic            wave_ack,
  input  logic            sw_valid,
  output logic            PCincr,
  output logic            PCabsbranch,
  output logic            PCrelbranch,
  output logic [2:0]      ALUfunc,
  output logic            imm,
  output logic            retrieve_switch,
  output logic            retrieve_wave,
  output logic            w,
  output logic            wave_req,
  output logic            wave_err,
  output logic            LED_status
);

  localparam int CW = $clog2(WAVE_TO + 1);
  localparam int LW = $clog2(LED_HOLD + 1);

  localparam logic [OPW-1:0] OP_NOP  = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(6'b000011);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001010);
  localparam logic [OPW-1:0] OP_SUBI = OPW'(6'b001011);
  localparam logic [OPW-1:0] OP_MULI = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(6'b010001);
  localparam logic [OPW-1:0] OP_LDW  = OPW'(6'b010101);
  localparam logic [OPW-1:0] OP_BRA  = OPW'(6'b011000);
  localparam logic [OPW-1:0] OP_DISP = OPW'(6'b011001);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b100000);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(6'b100001);
  localparam logic [OPW-1:0] OP_BGE  = OPW'(6'b100010);
  localparam logic [OPW-1:0] OP_BLO  = OPW'(6'b100011);

  typedef enum logic [1:0] {S_RUN, S_WAIT_WAVE, S_WAIT_SW} state_t;

  state_t        r_state, w_next_state;
  logic [CW-1:0] r_to_cnt, w_to_cnt_next;
  logic [LW-1:0] r_led_cnt;
  logic          r_wave_err;
  logic          w_led_load, w_err_set, w_legal, w_status;
  logic          w_unused_v;

  assign w_unused_v = flags[3];
  // Out-of-range channel selects read as status 0.
  assign w_status   = (32'(br_sel) < 32'(NCH)) ? branch_status[br_sel] : 1'b0;

  always_comb begin
    PCincr          = 1'b1;
    PCabsbranch     = 1'b0;
    PCrelbranch     = 1'b0;
    ALUfunc         = opcode[2:0];
    imm             = 1'b0;
    retrieve_switch = 1'b0;
    retrieve_wave   = 1'b0;
    w               = 1'b0;
    wave_req        = 1'b0;
    w_next_state    = r_state;
    w_to_cnt_next   = r_to_cnt;
    w_led_load      = 1'b0;
    w_err_set       = 1'b0;
    w_legal         = 1'b1;
    case (r_state)
      S_RUN: begin
        case (opcode)
          OP_NOP: ;
          OP_ADD, OP_SUB: w = 1'b1;
          OP_ADDI, OP_SUBI, OP_MULI: begin
            w   = 1'b1;
            imm = 1'b1;
          end
          OP_LDI: begin
            if (!SW_WAIT || sw_valid) begin
              w               = 1'b1;
              imm             = 1'b1;
              retrieve_switch = 1'b1;
            end else begin
              PCincr       = 1'b0;
              w_next_state = S_WAIT_SW;
            end
          end
          OP_LDW: begin
            wave_req      = 1'b1;
            PCincr        = 1'b0;
            w_next_state  = S_WAIT_WAVE;
            w_to_cnt_next = CW'(1);
          end
          OP_BRA: begin
            PCincr = 1'b0;
            if (w_status == branch_condition) PCabsbranch = 1'b1;
            if (w_status) w_led_load = 1'b1;
          end
          OP_DISP: w_led_load = 1'b1;
          OP_BEQ: if (flags[1])  begin PCincr = 1'b0; PCrelbranch = 1'b1; end
          OP_BNE: if (!flags[1]) begin PCincr = 1'b0; PCrelbranch = 1'b1; end
          OP_BGE: if (!flags[2]) begin PCincr = 1'b0; PCrelbranch = 1'b1; end
          OP_BLO: if (flags[0])  begin PCincr = 1'b0; PCrelbranch = 1'b1; end
          default: w_legal = 1'b0;
        endcase
      end
      S_WAIT_WAVE: begin
        wave_req      = 1'b1;
        retrieve_wave = 1'b1;
        PCincr        = 1'b0;
        // An ack arriving in the timeout cycle still completes the load.
        if (wave_ack) begin
          w            = 1'b1;
          PCincr       = 1'b1;
          wave_req     = 1'b0;
          w_next_state = S_RUN;
        end else if (r_to_cnt == CW'(WAVE_TO)) begin
          w_err_set    = 1'b1;
          PCincr       = 1'b1;
          wave_req     = 1'b0;
          w_next_state = S_RUN;
        end else begin
          w_to_cnt_next = r_to_cnt + CW'(1);
        end
      end
      S_WAIT_SW: begin
        imm             = 1'b1;
        retrieve_switch = 1'b1;
        PCincr          = 1'b0;
        if (sw_valid) begin
          w            = 1'b1;
          PCincr       = 1'b1;
          w_next_state = S_RUN;
        end
      end
      default: w_next_state = S_RUN;
    endcase
    if (!nreset) begin
      PCincr          = 1'b0;
      PCabsbranch     = 1'b0;
      PCrelbranch     = 1'b0;
      ALUfunc         = 3'b000;
      imm             = 1'b0;
      retrieve_switch = 1'b0;
      retrieve_wave   = 1'b0;
      w               = 1'b0;
      wave_req        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state    <= S_RUN;
      r_to_cnt   <= '0;
      r_led_cnt  <= '0;
      r_wave_err <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_to_cnt   <= w_to_cnt_next;
      r_wave_err <= r_wave_err | w_err_set;
      if (w_led_load)
        r_led_cnt <= LW'(LED_HOLD);
      else if (r_led_cnt != '0)
        r_led_cnt <= r_led_cnt - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (nreset && r_state == S_RUN)
      assert (w_legal) else $error("decoder_mc: undefined opcode %h", opcode);
  end

  assign wave_err   = r_wave_err;
  assign LED_status = (r_led_cnt != '0);

endmodule

// File: tb/tb_decoder_mc.sv
// Scoreboard bench for decoder_mc: the driver queues the expected output word for each
// cycle it drives; a negedge monitor pops and compares it against the DUT outputs.
module tb_decoder_mc;

  localparam logic [5:0] NOP  = 6'b000000, ADD  = 6'b000010, SUB  = 6'b000011;
  localparam logic [5:0] ADDI = 6'b001010, MULI = 6'b001100, LDI  = 6'b010001;
  localparam logic [5:0] LDW  = 6'b010101, BRA  = 6'b011000, DISP = 6'b011001;
  localparam logic [5:0] BEQ  = 6'b100000, BNE  = 6'b100001, BGE  = 6'b100010;
  localparam logic [5:0] BLO  = 6'b100011;

  logic       clk = 1'b0;
  logic       nreset;
  logic [5:0] opcode;
  logic [3:0] flags;
  logic [1:0] br_sel;
  logic       branch_condition;
  logic [3:0] branch_status;
  logic       wave_ack, sw_valid;
  logic       PCincr, PCabsbranch, PCrelbranch, imm, retrieve_switch, retrieve_wave;
  logic       w, wave_req, wave_err, LED_status;
  logic [2:0] ALUfunc;

  decoder_mc #(.OPW(6), .NCH(4), .WAVE_TO(4), .LED_HOLD(8), .SW_WAIT(1'b1)) dut (
    .clk(clk), .nreset(nreset), .opcode(opcode), .flags(flags), .br_sel(br_sel),
    .branch_condition(branch_condition), .branch_status(branch_status),
    .wave_ack(wave_ack), .sw_valid(sw_valid), .PCincr(PCincr), .PCabsbranch(PCabsbranch),
    .PCrelbranch(PCrelbranch), .ALUfunc(ALUfunc), .imm(imm), .retrieve_switch(retrieve_switch),
    .retrieve_wave(retrieve_wave), .w(w), .wave_req(wave_req), .wave_err(wave_err),
    .LED_status(LED_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [12:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [12:0] act;
  assign act = {PCincr, PCabsbranch, PCrelbranch, ALUfunc, imm, retrieve_switch,
                retrieve_wave, w, wave_req, wave_err, LED_status};

  // Field order: PCincr abs rel ALUfunc imm rsw rwave w wave_req wave_err LED
  function automatic logic [12:0] ex(input logic pci, abs, rel, input logic [2:0] alu,
                                     input logic im, rs, rw, we, wq, er, led);
    return {pci, abs, rel, alu, im, rs, rw, we, wq, er, led};
  endfunction

  task automatic drive(input string nm, input logic [12:0] exp);
    sb.push_back('{nm, exp});
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b (PCi abs rel alu imm rsw rwv w wreq err led)",
                 e.nm, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0; opcode = ADD; flags = 4'b0000; br_sel = 2'd0;
    branch_condition = 1'b0; branch_status = 4'b0000; wave_ack = 1'b0; sw_valid = 1'b0;
    @(posedge clk); #1;

    // Reset holds every output low
    drive("reset_c0", ex(0,0,0,3'b000,0,0,0,0,0,0,0));
    drive("reset_c1", ex(0,0,0,3'b000,0,0,0,0,0,0,0));
    nreset = 1'b1;
    drive("add",  ex(1,0,0,3'b010,0,0,0,1,0,0,0));
    opcode = SUB;  drive("sub",  ex(1,0,0,3'b011,0,0,0,1,0,0,0));
    opcode = ADDI; drive("addi", ex(1,0,0,3'b010,1,0,0,1,0,0,0));
    opcode = MULI; drive("muli", ex(1,0,0,3'b100,1,0,0,1,0,0,0));
    opcode = NOP;  drive("nop",  ex(1,0,0,3'b000,0,0,0,0,0,0,0));

    // LDW, ack on the fourth wait cycle (also the timeout cycle: ack wins)
    opcode = LDW;
    drive("ldw_entry", ex(0,0,0,3'b101,0,0,0,0,1,0,0));
    for (int i = 1; i <= 3; i++) drive($sformatf("ldw_wait%0d", i), ex(0,0,0,3'b101,0,0,1,0,1,0,0));
    wave_ack = 1'b1;
    drive("ldw_ack", ex(1,0,0,3'b101,0,0,1,1,0,0,0));
    wave_ack = 1'b0; opcode = ADD;
    drive("add_after_ack", ex(1,0,0,3'b010,0,0,0,1,0,0,0));

    // LDW with no ack: timeout after counter reaches 4
    opcode = LDW;
    drive("ldwto_entry", ex(0,0,0,3'b101,0,0,0,0,1,0,0));
    for (int i = 1; i <= 3; i++) drive($sformatf("ldwto_wait%0d", i), ex(0,0,0,3'b101,0,0,1,0,1,0,0));
    drive("ldwto_timeout", ex(1,0,0,3'b101,0,0,1,0,0,0,0));
    opcode = ADD;
    drive("add_after_to", ex(1,0,0,3'b010,0,0,0,1,0,1,0));
    opcode = NOP;
    drive("err_sticky", ex(1,0,0,3'b000,0,0,0,0,0,1,0));

    // LDI waiting for the switch, strobe on cycle 5
    opcode = LDI;
    drive("ldi_entry", ex(0,0,0,3'b001,0,0,0,0,0,1,0));
    for (int i = 2; i <= 4; i++) drive($sformatf("ldi_wait%0d", i), ex(0,0,0,3'b001,1,1,0,0,0,1,0));
    sw_valid = 1'b1;
    drive("ldi_done", ex(1,0,0,3'b001,1,1,0,1,0,1,0));
    drive("ldi_zero_wait", ex(1,0,0,3'b001,1,1,0,1,0,1,0));
    sw_valid = 1'b0; opcode = NOP;
    drive("nop_after_ldi", ex(1,0,0,3'b000,0,0,0,0,0,1,0));

    // BRA channel 2, status set, condition 1: taken, LED for 8 cycles
    opcode = BRA; br_sel = 2'd2; branch_status = 4'b0100; branch_condition = 1'b1;
    drive("bra_taken", ex(0,1,0,3'b000,0,0,0,0,0,1,0));
    opcode = NOP;
    for (int i = 1; i <= 8; i++) drive($sformatf("bra_led%0d", i), ex(1,0,0,3'b000,0,0,0,0,0,1,1));
    drive("bra_led_off", ex(1,0,0,3'b000,0,0,0,0,0,1,0));
    opcode = BRA; branch_condition = 1'b0;
    drive("bra_hold", ex(0,0,0,3'b000,0,0,0,0,0,1,0));
    opcode = NOP;
    drive("bra_hold_led", ex(1,0,0,3'b000,0,0,0,0,0,1,1));
    for (int i = 2; i <= 8; i++) drive($sformatf("bra_hold_led%0d", i), ex(1,0,0,3'b000,0,0,0,0,0,1,1));
    drive("bra_hold_led_off", ex(1,0,0,3'b000,0,0,0,0,0,1,0));
    opcode = BRA; br_sel = 2'd3;
    drive("bra_ch3", ex(0,1,0,3'b000,0,0,0,0,0,1,0));
    opcode = NOP;
    drive("bra_ch3_noled", ex(1,0,0,3'b000,0,0,0,0,0,1,0));

    // Flag branches with Z=1, N=0, C=0
    flags = 4'b0010;
    opcode = BEQ; drive("beq", ex(0,0,1,3'b000,0,0,0,0,0,1,0));
    opcode = BNE; drive("bne", ex(1,0,0,3'b001,0,0,0,0,0,1,0));
    opcode = BGE; drive("bge", ex(0,0,1,3'b010,0,0,0,0,0,1,0));
    opcode = BLO; drive("blo", ex(1,0,0,3'b011,0,0,0,0,0,1,0));
    flags = 4'b0000;

    // DISP reload after 3 cycles: LED high 11 cycles
    opcode = DISP; drive("disp0", ex(1,0,0,3'b001,0,0,0,0,0,1,0));
    opcode = NOP;
    drive("disp_led1", ex(1,0,0,3'b000,0,0,0,0,0,1,1));
    drive("disp_led2", ex(1,0,0,3'b000,0,0,0,0,0,1,1));
    opcode = DISP; drive("disp_reload", ex(1,0,0,3'b001,0,0,0,0,0,1,1));
    opcode = NOP;
    for (int i = 4; i <= 11; i++) drive($sformatf("disp_led%0d", i), ex(1,0,0,3'b000,0,0,0,0,0,1,1));
    drive("disp_led_off", ex(1,0,0,3'b000,0,0,0,0,0,1,0));

    // Reset while waiting on the wave: no write, error cleared
    opcode = LDW;
    drive("rstw_entry", ex(0,0,0,3'b101,0,0,0,0,1,1,0));
    drive("rstw_wait1", ex(0,0,0,3'b101,0,0,1,0,1,1,0));
    nreset = 1'b0; wave_ack = 1'b1;
    drive("rstw_reset", ex(0,0,0,3'b000,0,0,0,0,0,1,0));
    nreset = 1'b1; wave_ack = 1'b0; opcode = ADD;
    drive("rstw_add", ex(1,0,0,3'b010,0,0,0,1,0,0,0));

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
